trdb_commit_stager: RTL and testbench

- Upstream neighbour of the itype detector. Captures single-retire commit information from the CVA6 commit port.
- Buffers commits in a small FIFO.
- Presents a 3-deep shift window: previous (pc), current (cc) and next (nc) instruction, with per-slot valids.
- The cc_* slot carries the full instruction attributes the detector consumes. pc/nc carry only address and valid.

---
 rtl/mure_pkg.sv | 5 +
 rtl/trdb_commit_stager.sv | 178 +++++++++++++++++
 tb/tb_trdb_commit_stager.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mure_pkg.sv
// mure_pkg: shared trace-debugger constants.
//   XLEN - architectural register / address width seen on the commit port.
package mure_pkg;
    localparam int unsigned XLEN = 32;
endpackage

// File: rtl/trdb_commit_stager.sv
// trdb_commit_stager
// Captures single-retire commits from the core commit port into a small FIFO
// and presents a sliding 3-instruction window: previous (pc), current (cc) and
// next (nc). Only the cc slot exposes the full instruction attributes; pc and
// nc expose address and valid.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   commit_*_i             commit port entry (valid, address, word, attributes)
//   flush_i                start draining: bubbles shift in until window empty
//   ready_i                downstream accepts a window shift this cycle
//   pc/cc/nc_valid_o       slot valids
//   pc/cc/nc_iaddr_o       slot addresses
//   cc_inst_data_o, cc_*_o current instruction word and attributes (0 if !cc_valid_o)
//   fifo_count_o           commit FIFO occupancy
//   overflow_o             sticky: a commit was dropped because the FIFO was full
//   cc_timestamp_o         (only with TRDB_COMMIT_TIMESTAMP_EN) cycle count at push
//
// Build option: define TRDB_COMMIT_TIMESTAMP_EN to add a free-running 32-bit
// cycle counter whose value is captured with each commit and reported with cc.
//
// Handshake: a window shift happens on any edge where ready_i is high and there
// is something to shift in (a FIFO entry, or a bubble while draining a
// non-empty window). Commits have no backpressure; a commit that finds the FIFO
// full with no pop in the same cycle is dropped and flagged on overflow_o.
module trdb_commit_stager #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ILEN       = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            commit_valid_i,
    input  logic [mure_pkg::XLEN-1:0]       commit_iaddr_i,
    input  logic [ILEN-1:0]                 commit_inst_i,
    input  logic                            commit_compressed_i,
    input  logic                            commit_exception_i,
    input  logic                            commit_interrupt_i,
    input  logic                            commit_eret_i,
    input  logic                            flush_i,
    input  logic                            ready_i,
    output logic                            pc_valid_o,
    output logic                            cc_valid_o,
    output logic                            nc_valid_o,
    output logic [mure_pkg::XLEN-1:0]       pc_iaddr_o,
    output logic [mure_pkg::XLEN-1:0]       cc_iaddr_o,
    output logic [mure_pkg::XLEN-1:0]       nc_iaddr_o,
    output logic [ILEN-1:0]                 cc_inst_data_o,
    output logic                            cc_compressed_o,
    output logic                            cc_exception_o,
    output logic                            cc_interrupt_o,
    output logic                            cc_eret_o,
`ifdef TRDB_COMMIT_TIMESTAMP_EN
    output logic [31:0]                     cc_timestamp_o,
`endif
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
    output logic                            overflow_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [mure_pkg::XLEN-1:0] iaddr;
        logic [ILEN-1:0]           inst;
        logic                      compressed;
        logic                      exception;
        logic                      interrupt;
        logic                      eret;
`ifdef TRDB_COMMIT_TIMESTAMP_EN
        logic [31:0]               ts;
`endif
    } entry_t;

    entry_t                    mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             count_q;
    logic                      overflow_q;
    logic                      drain_q, drain_d;

    logic                      pc_valid_q, cc_valid_q, nc_valid_q;
    logic [mure_pkg::XLEN-1:0] pc_iaddr_q;
    entry_t                    cc_q, nc_q;

`ifdef TRDB_COMMIT_TIMESTAMP_EN
    logic [31:0]               cycle_q;
`endif

    logic   fifo_empty, fifo_full, any_valid;
    logic   shift, pop, push, drop;
    entry_t new_entry;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        any_valid  = pc_valid_q | cc_valid_q | nc_valid_q;
        // While draining, an empty FIFO still lets the window advance with bubbles.
        shift      = ready_i && (!fifo_empty || (drain_q && any_valid));
        pop        = shift && !fifo_empty;
        // A full FIFO still accepts a commit when the head leaves the same cycle.
        push       = commit_valid_i && (!fifo_full || pop);
        drop       = commit_valid_i && fifo_full && !pop;
        drain_d    = flush_i || (drain_q && (any_valid || !fifo_empty));

        new_entry            = '0;
        new_entry.iaddr      = commit_iaddr_i;
        new_entry.inst       = commit_inst_i;
        new_entry.compressed = commit_compressed_i;
        new_entry.exception  = commit_exception_i;
        new_entry.interrupt  = commit_interrupt_i;
        new_entry.eret       = commit_eret_i;
`ifdef TRDB_COMMIT_TIMESTAMP_EN
        new_entry.ts         = cycle_q;
`endif
    end

    // FIFO storage carries no reset: entries are only observed after a push.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drain_q    <= 1'b0;
            pc_valid_q <= 1'b0;
            cc_valid_q <= 1'b0;
            nc_valid_q <= 1'b0;
            pc_iaddr_q <= '0;
            cc_q       <= '0;
            nc_q       <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
            if (drop) overflow_q <= 1'b1;
            drain_q <= drain_d;

            if (shift) begin
                pc_valid_q <= cc_valid_q;
                pc_iaddr_q <= cc_q.iaddr;
                cc_valid_q <= nc_valid_q;
                cc_q       <= nc_q;
                nc_valid_q <= pop;
                // A bubble leaves the nc fields untouched; only the valid drops.
                if (pop) nc_q <= mem_q[rd_ptr_q];
            end
        end
    end

`ifdef TRDB_COMMIT_TIMESTAMP_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) cycle_q <= '0;
        else       cycle_q <= cycle_q + 32'd1;
    end

    assign cc_timestamp_o = cc_valid_q ? cc_q.ts : 32'd0;
`endif

    assign pc_valid_o      = pc_valid_q;
    assign cc_valid_o      = cc_valid_q;
    assign nc_valid_o      = nc_valid_q;
    assign pc_iaddr_o      = pc_iaddr_q;
    assign cc_iaddr_o      = cc_q.iaddr;
    assign nc_iaddr_o      = nc_q.iaddr;
    assign cc_inst_data_o  = cc_valid_q ? cc_q.inst : '0;
    assign cc_compressed_o = cc_valid_q & cc_q.compressed;
    assign cc_exception_o  = cc_valid_q & cc_q.exception;
    assign cc_interrupt_o  = cc_valid_q & cc_q.interrupt;
    assign cc_eret_o       = cc_valid_q & cc_q.eret;
    assign fifo_count_o    = count_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_trdb_commit_stager.sv
module tb_trdb_commit_stager;
    localparam int unsigned XLEN = mure_pkg::XLEN;
    localparam int unsigned ILEN = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_i = 1'b1;
    logic            commit_valid_i = 1'b0;
    logic [XLEN-1:0] commit_iaddr_i = '0;
    logic [ILEN-1:0] commit_inst_i = '0;
    logic            commit_compressed_i = 1'b0;
    logic            commit_exception_i = 1'b0;
    logic            commit_interrupt_i = 1'b0;
    logic            commit_eret_i = 1'b0;
    logic            flush_i = 1'b0;
    logic            ready_i = 1'b0;
    logic            pc_valid_o, cc_valid_o, nc_valid_o;
    logic [XLEN-1:0] pc_iaddr_o, cc_iaddr_o, nc_iaddr_o;
    logic [ILEN-1:0] cc_inst_data_o;
    logic            cc_compressed_o, cc_exception_o, cc_interrupt_o, cc_eret_o;
    logic [2:0]      fifo_count_o;
    logic            overflow_o;
`ifdef TRDB_COMMIT_TIMESTAMP_EN
    logic [31:0]     cc_timestamp_o;
`endif

    trdb_commit_stager #(.FIFO_DEPTH(4), .ILEN(ILEN)) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .commit_valid_i      (commit_valid_i),
        .commit_iaddr_i      (commit_iaddr_i),
        .commit_inst_i       (commit_inst_i),
        .commit_compressed_i (commit_compressed_i),
        .commit_exception_i  (commit_exception_i),
        .commit_interrupt_i  (commit_interrupt_i),
        .commit_eret_i       (commit_eret_i),
        .flush_i             (flush_i),
        .ready_i             (ready_i),
        .pc_valid_o          (pc_valid_o),
        .cc_valid_o          (cc_valid_o),
        .nc_valid_o          (nc_valid_o),
        .pc_iaddr_o          (pc_iaddr_o),
        .cc_iaddr_o          (cc_iaddr_o),
        .nc_iaddr_o          (nc_iaddr_o),
        .cc_inst_data_o      (cc_inst_data_o),
        .cc_compressed_o     (cc_compressed_o),
        .cc_exception_o      (cc_exception_o),
        .cc_interrupt_o      (cc_interrupt_o),
        .cc_eret_o           (cc_eret_o),
`ifdef TRDB_COMMIT_TIMESTAMP_EN
        .cc_timestamp_o      (cc_timestamp_o),
`endif
        .fifo_count_o        (fifo_count_o),
        .overflow_o          (overflow_o)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        commit_valid_i      = 1'b0;
        commit_iaddr_i      = '0;
        commit_inst_i       = '0;
        commit_compressed_i = 1'b0;
        commit_exception_i  = 1'b0;
        commit_interrupt_i  = 1'b0;
        commit_eret_i       = 1'b0;
        flush_i             = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Present one commit for exactly one edge.
    task automatic commit(input logic [XLEN-1:0] addr, input logic [ILEN-1:0] inst,
                          input logic [3:0] attr);
        commit_valid_i      = 1'b1;
        commit_iaddr_i      = addr;
        commit_inst_i       = inst;
        commit_compressed_i = attr[3];
        commit_exception_i  = attr[2];
        commit_interrupt_i  = attr[1];
        commit_eret_i       = attr[0];
        tick();
        idle_inputs();
    endtask

    task automatic check_window(input string tag, input logic [2:0] v,
                                input logic [XLEN-1:0] pa, input logic [XLEN-1:0] ca,
                                input logic [XLEN-1:0] na);
        check_eq({tag, ".pc_valid"}, 64'(pc_valid_o), 64'(v[2]));
        check_eq({tag, ".cc_valid"}, 64'(cc_valid_o), 64'(v[1]));
        check_eq({tag, ".nc_valid"}, 64'(nc_valid_o), 64'(v[0]));
        if (v[2]) check_eq({tag, ".pc_iaddr"}, 64'(pc_iaddr_o), 64'(pa));
        if (v[1]) check_eq({tag, ".cc_iaddr"}, 64'(cc_iaddr_o), 64'(ca));
        if (v[0]) check_eq({tag, ".nc_iaddr"}, 64'(nc_iaddr_o), 64'(na));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        do_reset();
        check_window("rst", 3'b000, '0, '0, '0);
        check_eq("rst.count", 64'(fifo_count_o), 64'd0);
        check_eq("rst.ovf", 64'(overflow_o), 64'd0);
        check_eq("rst.cc_inst", 64'(cc_inst_data_o), 64'd0);
        check_eq("rst.cc_attr", 64'({cc_compressed_o, cc_exception_o, cc_interrupt_o, cc_eret_o}), 64'd0);

        // Continuous flow: no bypass, one slot per cycle.
        ready_i = 1'b1;
        commit(32'h8000_0000, 32'h0000_0013, 4'b0000);
        check_eq("flow.count1", 64'(fifo_count_o), 64'd1);
        check_eq("flow.nobypass", 64'(nc_valid_o), 64'd0);
        commit(32'h8000_0004, 32'h0000_0013, 4'b0000);
        check_window("flow.e2", 3'b001, '0, '0, 32'h8000_0000);
        commit(32'h8000_0008, 32'h0000_0013, 4'b0000);
        check_window("flow.e3", 3'b011, '0, 32'h8000_0000, 32'h8000_0004);
        tick();
        check_window("flow.e4", 3'b111, 32'h8000_0000, 32'h8000_0004, 32'h8000_0008);
        tick();
        check_window("flow.e5", 3'b111, 32'h8000_0000, 32'h8000_0004, 32'h8000_0008);
        check_eq("flow.count0", 64'(fifo_count_o), 64'd0);

        // Overflow: six commits with the window stalled.
        do_reset();
        ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            commit(32'h0000_0200 + 32'(4 * i), 32'h0000_0013, 4'b0000);
            check_eq($sformatf("ovf.count%0d", i), 64'(fifo_count_o), 64'((i < 4) ? i + 1 : 4));
            check_eq($sformatf("ovf.flag%0d", i), 64'(overflow_o), 64'((i >= 4) ? 1 : 0));
        end
        check_eq("ovf.stall", 64'(nc_valid_o), 64'd0);
        ready_i = 1'b1;
        tick();
        check_window("ovf.o1", 3'b001, '0, '0, 32'h200);
        tick();
        check_window("ovf.o2", 3'b011, '0, 32'h200, 32'h204);
        tick();
        check_window("ovf.o3", 3'b111, 32'h200, 32'h204, 32'h208);
        tick();
        check_window("ovf.o4", 3'b111, 32'h204, 32'h208, 32'h20C);
        check_eq("ovf.count_end", 64'(fifo_count_o), 64'd0);
        check_eq("ovf.sticky", 64'(overflow_o), 64'd1);

        // Mid-stream reset with three entries and an in-flight commit.
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) commit(32'h0000_0500 + 32'(4 * i), 32'h0000_0013, 4'b0000);
        check_eq("mrst.count3", 64'(fifo_count_o), 64'd3);
        rst_i = 1'b1;
        commit_valid_i = 1'b1;
        commit_iaddr_i = 32'h0000_0600;
        tick();
        rst_i = 1'b0;
        idle_inputs();
        ready_i = 1'b1;
        check_window("mrst", 3'b000, '0, '0, '0);
        check_eq("mrst.count", 64'(fifo_count_o), 64'd0);
        check_eq("mrst.ovf", 64'(overflow_o), 64'd0);
        tick();
        check_eq("mrst.discard", 64'(fifo_count_o), 64'd0);
        check_eq("mrst.nc_empty", 64'(nc_valid_o), 64'd0);

        // Branch instruction word carried into cc.
        do_reset();
        ready_i = 1'b1;
        commit(32'h0000_0100, 32'h00B5_0463, 4'b0000);
        commit(32'h0000_0108, 32'h0000_0013, 4'b0100);
        tick();
        check_window("beq", 3'b011, '0, 32'h100, 32'h108);
        check_eq("beq.inst", 64'(cc_inst_data_o), 64'h00B5_0463);
        check_eq("beq.comp", 64'(cc_compressed_o), 64'd0);
        check_eq("beq.exc", 64'(cc_exception_o), 64'd0);

        // Drain: three commits then a flush pulse.
        do_reset();
        ready_i = 1'b1;
        commit(32'h0000_0300, 32'h0000_0013, 4'b0010);
        commit(32'h0000_0302, 32'h0000_4501, 4'b1000);
        commit(32'h0000_0304, 32'h3020_0073, 4'b0001);
        tick();
        check_window("drn.full", 3'b111, 32'h300, 32'h302, 32'h304);
        check_eq("drn.cc_comp", 64'(cc_compressed_o), 64'd1);
        check_eq("drn.cc_int", 64'(cc_interrupt_o), 64'd0);
        check_eq("drn.cc_inst", 64'(cc_inst_data_o), 64'h0000_4501);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_window("drn.f0", 3'b111, 32'h300, 32'h302, 32'h304);
        tick();
        check_window("drn.b1", 3'b110, 32'h302, 32'h304, '0);
        check_eq("drn.b1_eret", 64'(cc_eret_o), 64'd1);
        check_eq("drn.b1_inst", 64'(cc_inst_data_o), 64'h3020_0073);
        tick();
        check_window("drn.b2", 3'b100, 32'h304, '0, '0);
        check_eq("drn.b2_eret0", 64'(cc_eret_o), 64'd0);
        check_eq("drn.b2_inst0", 64'(cc_inst_data_o), 64'd0);
        tick();
        check_window("drn.b3", 3'b000, '0, '0, '0);
        tick();
        // Drain must be over: a fresh commit parks in nc and goes no further.
        commit(32'h0000_0700, 32'h0000_0013, 4'b0000);
        tick();
        tick();
        check_window("drn.done", 3'b001, '0, '0, 32'h700);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) commit(32'h0000_0400 + 32'(4 * i), 32'h0000_0013, 4'b0000);
        check_eq("fpp.full", 64'(fifo_count_o), 64'd4);
        ready_i = 1'b1;
        commit(32'h0000_0410, 32'h0000_0013, 4'b0000);
        check_eq("fpp.count", 64'(fifo_count_o), 64'd4);
        check_eq("fpp.ovf", 64'(overflow_o), 64'd0);
        check_window("fpp.nc", 3'b001, '0, '0, 32'h400);
        tick();
        check_eq("fpp.count3", 64'(fifo_count_o), 64'd3);
        for (int i = 0; i < 3; i++) tick();
        check_window("fpp.tail", 3'b111, 32'h408, 32'h40C, 32'h410);

`ifdef TRDB_COMMIT_TIMESTAMP_EN
        // Timestamp: commit pushed after ten cycles out of reset.
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        commit(32'h0000_0900, 32'h0000_0013, 4'b0000);
        commit(32'h0000_0904, 32'h0000_0013, 4'b0000);
        tick();
        check_window("ts", 3'b011, '0, 32'h900, 32'h904);
        check_eq("ts.value", 64'(cc_timestamp_o), 64'd10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
